// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter between NUM_REQ clients. Pending requests
// are arbitrated round-robin. The winner's byte and frame configuration are
// latched, the transmitter is started, and the block waits for tx_done or a
// watchdog timeout. The client then gets a one-cycle done or error pulse.
//
// Parameters
//   NUM_REQ  number of clients (2..8)
//   TIMEOUT  cycles allowed from tx_start to tx_done before the frame is
//            abandoned (>= 16)
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req[NUM_REQ]             level request per client, held until its grant
//   req_data                 byte per client, client i at [8i+7:8i]
//   req_parity_type          2 bits per client (00 none, 01 odd, 10 even)
//   req_frame_length         4 bits per client, data bits 5..8
//   req_stop_bit_type        1 bit per client (0 one, 1 two stop bits)
//   grant / cli_done / cli_err  one-hot, one-cycle pulses per client
//   tx_start                 one-cycle start pulse to the transmitter
//   tx_data, parity_type, frame_length, stop_bit_type  latched frame config
//   tx_done                  end-of-frame pulse from the transmitter
//   busy                     high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [2*NUM_REQ-1:0]   req_parity_type,
  input  logic [4*NUM_REQ-1:0]   req_frame_length,
  input  logic [NUM_REQ-1:0]     req_stop_bit_type,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     cli_done,
  output logic [NUM_REQ-1:0]     cli_err,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [1:0]             parity_type,
  output logic [3:0]             frame_length,
  output logic                   stop_bit_type,
  input  logic                   tx_done,
  output logic                   busy
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_WAIT,
    S_FINISH
  } state_t;

  // Per-client views of the packed configuration buses.
  logic [7:0] cli_data  [NUM_REQ];
  logic [1:0] cli_par   [NUM_REQ];
  logic [3:0] cli_len   [NUM_REQ];
  logic       cli_stop  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign cli_data[gi] = req_data[8*gi +: 8];
    assign cli_par[gi]  = req_parity_type[2*gi +: 2];
    assign cli_len[gi]  = req_frame_length[4*gi +: 4];
    assign cli_stop[gi] = req_stop_bit_type[gi];
  end

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] cli_done_q, cli_done_d;
  logic [NUM_REQ-1:0] cli_err_q, cli_err_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [1:0]         parity_q, parity_d;
  logic [3:0]         len_q, len_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;

  // Round-robin pick: first set request at or above rr_ptr, wrapping.
  // Scanning offsets from high to low lets the smallest offset win last.
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  always_comb begin : comb_arb
    int idx_int;
    logic [SEL_W-1:0] idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx_int    = 0;
    idx        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_int = int'(rr_ptr_q) + k;
      if (idx_int >= NUM_REQ) begin
        idx_int = idx_int - NUM_REQ;
      end
      idx = SEL_W'(idx_int);
      if (req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  logic [NUM_REQ-1:0] sel_onehot;
  assign sel_onehot = NUM_REQ'(1) << sel_q;

  always_comb begin : comb_next
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    wd_d       = wd_q;
    tx_data_d  = tx_data_q;
    parity_d   = parity_q;
    len_d      = len_q;
    stop_d     = stop_q;
    grant_d    = '0;
    cli_done_d = '0;
    cli_err_d  = '0;
    tx_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        // Configuration is taken from whatever the client drives now,
        // even if its request has already been withdrawn.
        tx_data_d = cli_data[sel_q];
        parity_d  = (cli_par[sel_q] == 2'b11) ? 2'b00 : cli_par[sel_q];
        len_d     = (cli_len[sel_q] < 4'd5 || cli_len[sel_q] > 4'd8)
                    ? 4'd8 : cli_len[sel_q];
        stop_d    = cli_stop[sel_q];
        rr_ptr_d  = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        tx_start_d = 1'b1;
        state_d    = S_START;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // tx_done takes precedence over a timeout in the same cycle.
        if (tx_done) begin
          cli_done_d = sel_onehot;
          state_d    = S_FINISH;
        end else if (wd_q == WD_LAST) begin
          cli_err_d = sel_onehot;
          state_d   = S_FINISH;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      wd_q       <= '0;
      grant_q    <= '0;
      cli_done_q <= '0;
      cli_err_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      parity_q   <= 2'b00;
      len_q      <= 4'd8;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      wd_q       <= wd_d;
      grant_q    <= grant_d;
      cli_done_q <= cli_done_d;
      cli_err_q  <= cli_err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      parity_q   <= parity_d;
      len_q      <= len_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  assign grant         = grant_q;
  assign cli_done      = cli_done_q;
  assign cli_err       = cli_err_q;
  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign parity_type   = parity_q;
  assign frame_length  = len_q;
  assign stop_bit_type = stop_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Randomized transaction-level bench for uart_tx_arbiter. A reference model
// keeps the set of pending clients, the round-robin pointer and each client's
// configuration, and predicts the winner, latched frame config and the cycle
// of the done/error pulse for every frame. Occasional mid-frame resets check
// the abort path and the pointer returning to client 0.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [2*N-1:0]   req_parity_type;
  logic [4*N-1:0]   req_frame_length;
  logic [N-1:0]     req_stop_bit_type;
  logic [N-1:0]     grant;
  logic [N-1:0]     cli_done;
  logic [N-1:0]     cli_err;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [1:0]       parity_type;
  logic [3:0]       frame_length;
  logic             stop_bit_type;
  logic             tx_done;
  logic             busy;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .req_data          (req_data),
    .req_parity_type   (req_parity_type),
    .req_frame_length  (req_frame_length),
    .req_stop_bit_type (req_stop_bit_type),
    .grant             (grant),
    .cli_done          (cli_done),
    .cli_err           (cli_err),
    .tx_start          (tx_start),
    .tx_data           (tx_data),
    .parity_type       (parity_type),
    .frame_length      (frame_length),
    .stop_bit_type     (stop_bit_type),
    .tx_done           (tx_done),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int           rr;
  logic [N-1:0] pending;
  logic [7:0]   m_data [N];
  logic [1:0]   m_par  [N];
  logic [3:0]   m_len  [N];
  logic         m_stop [N];

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  task automatic randomize_client(input int i);
    m_data[i] = 8'($urandom);
    m_par[i]  = 2'($urandom);
    m_len[i]  = 4'($urandom);
    m_stop[i] = 1'($urandom);
  endtask

  task automatic drive_cfg();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8]         = m_data[i];
      req_parity_type[2*i +: 2]  = m_par[i];
      req_frame_length[4*i +: 4] = m_len[i];
      req_stop_bit_type[i]       = m_stop[i];
    end
  endtask

  initial begin
    int w, d, f, sel_choice;
    logic [7:0] e_data;
    logic [1:0] e_par;
    logic [3:0] e_len;
    logic       e_stop;
    logic       inject_rst, aborted;

    rst = 1'b1;
    req = '0;
    tx_done = 1'b0;
    req_data = '0;
    req_parity_type = '0;
    req_frame_length = '0;
    req_stop_bit_type = '0;
    rr = 0;
    pending = '0;
    for (int i = 0; i < N; i++) randomize_client(i);

    repeat (2) @(negedge clk);
    check_eq("rst_busy",     32'(busy), 32'd0);
    check_eq("rst_grant",    32'(grant), 32'd0);
    check_eq("rst_pulses",   32'({cli_done, cli_err, tx_start}), 32'd0);
    check_eq("rst_len",      32'(frame_length), 32'd8);
    check_eq("rst_par",      32'(parity_type), 32'd0);
    check_eq("rst_data",     32'(tx_data), 32'd0);
    rst = 1'b0;

    for (int t = 0; t < 150; t++) begin
      // DUT is idle at this negedge.
      if (pending == '0 && ($urandom % 2) == 0) begin
        repeat (2) begin
          @(negedge clk);
          check_eq("idle_busy",  32'(busy), 32'd0);
          check_eq("idle_grant", 32'(grant), 32'd0);
        end
      end
      pending = pending | N'($urandom);
      if (pending == '0) pending[$urandom % N] = 1'b1;
      for (int i = 0; i < N; i++) randomize_client(i);
      drive_cfg();
      req = pending;
      tx_done = 1'b0;
      w = pick(pending, rr);

      // LATCH cycle: grant visible
      @(negedge clk);
      check_eq("grant", 32'(grant), 32'(onehot(w)));
      check_eq("latch_busy", 32'(busy), 32'd1);
      check_eq("latch_txstart", 32'(tx_start), 32'd0);
      pending[w] = 1'b0;
      rr = (w + 1) % N;
      req = pending;
      // Config driven during LATCH is what gets latched.
      if (($urandom % 2) == 0) begin
        randomize_client(w);
        drive_cfg();
      end
      e_data = m_data[w];
      e_par  = (m_par[w] == 2'b11) ? 2'b00 : m_par[w];
      e_len  = (m_len[w] >= 4'd5 && m_len[w] <= 4'd8) ? m_len[w] : 4'd8;
      e_stop = m_stop[w];
      tx_done = (($urandom % 4) == 0); // ignored outside WAIT

      // START cycle
      @(negedge clk);
      check_eq("tx_start", 32'(tx_start), 32'd1);
      check_eq("start_grant", 32'(grant), 32'd0);
      check_eq("tx_data", 32'(tx_data), 32'(e_data));
      check_eq("parity_type", 32'(parity_type), 32'(e_par));
      check_eq("frame_length", 32'(frame_length), 32'(e_len));
      check_eq("stop_bit_type", 32'(stop_bit_type), 32'(e_stop));
      tx_done = 1'b0;

      sel_choice = int'($urandom % 8);
      if (sel_choice == 0)      d = TO;            // coincident with last watchdog cycle
      else if (sel_choice == 1) d = TO + 1;        // never answered: timeout
      else                      d = 1 + int'($urandom % 8);
      f = (d <= TO) ? d + 1 : TO + 1;
      inject_rst = (($urandom % 10) == 0) && (f > 3);
      aborted = 1'b0;

      for (int c = 1; c <= f; c++) begin
        @(negedge clk);
        if (c < f) begin
          check_eq("wait_quiet", 32'({cli_done, cli_err, tx_start, grant}), 32'd0);
          check_eq("wait_busy", 32'(busy), 32'd1);
          if (inject_rst && c == 2) begin
            #2 rst = 1'b1;
            #1;
            check_eq("arst_busy", 32'(busy), 32'd0);
            check_eq("arst_pulses", 32'({cli_done, cli_err, tx_start}), 32'd0);
            check_eq("arst_len", 32'(frame_length), 32'd8);
            tx_done = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            rr = 0;
            aborted = 1'b1;
            break;
          end
          tx_done = (c == d);
        end else begin
          check_eq("cli_done", 32'(cli_done), (d <= TO) ? 32'(onehot(w)) : 32'd0);
          check_eq("cli_err",  32'(cli_err),  (d <= TO) ? 32'd0 : 32'(onehot(w)));
          check_eq("hold_len", 32'(frame_length), 32'(e_len));
          check_eq("hold_data", 32'(tx_data), 32'(e_data));
          tx_done = (($urandom % 3) == 0); // ignored in FINISH
        end
      end

      if (!aborted) begin
        @(negedge clk);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_pulses", 32'({cli_done, cli_err}), 32'd0);
        tx_done = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
